// File: rtl/updown_sweep_ctrl_if.sv
// Bundle of control, limit, feedback and status signals for the sweep controller.
// master = the environment (stimulus + counter); slave = the controller.
interface updown_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] lo_lim;
  logic [7:0] hi_lim;
  logic [3:0] n_sweeps;
  logic [7:0] count;
  logic       cnt_en;
  logic       cnt_dir;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_cnt;

  modport master (
    output start, abort, lo_lim, hi_lim, n_sweeps, count,
    input  cnt_en, cnt_dir, cnt_clr, busy, done, err, sweep_cnt
  );

  modport slave (
    input  start, abort, lo_lim, hi_lim, n_sweeps, count,
    output cnt_en, cnt_dir, cnt_clr, busy, done, err, sweep_cnt
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Drives an external up/down counter in a triangle between latched lo/hi limits.
// Latency: outputs are Moore-decoded from state; err is registered one cycle after a rejected start.
// Flow control: start is accepted in IDLE only; abort returns to IDLE on the next edge.
module updown_sweep_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  updown_sweep_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic [3:0] n_q;
  logic [3:0] sweep_q;
  logic       err_q;

  // Start request seen in IDLE; abort masks it. Limits checked on the live inputs.
  logic       start_req;
  logic       lim_ok;
  logic [7:0] hi_m1;
  logic [7:0] lo_p1;
  logic [3:0] sweep_inc;
  logic       at_top;
  logic       at_bottom;

  assign start_req = (state == IDLE) && bus.start && !bus.abort;
  assign lim_ok    = (bus.lo_lim < bus.hi_lim) && (bus.n_sweeps != 4'd0);
  // lo < hi is guaranteed for latched values, so neither of these can wrap.
  assign hi_m1     = hi_q - 8'd1;
  assign lo_p1     = lo_q + 8'd1;
  assign sweep_inc = sweep_q + 4'd1;
  // The counter reaches the turn-around value on the same edge the state flips.
  assign at_top    = (bus.count == hi_m1);
  assign at_bottom = (bus.count == lo_p1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_req && lim_ok) state_nxt = CLEAR;
        CLEAR:   state_nxt = UP;
        UP:      if (at_top) state_nxt = DOWN;
        DOWN:    if (at_bottom) state_nxt = (sweep_inc == n_q) ? DONE : UP;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Limit latch, sweep counter and rejected-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      n_q     <= 4'd0;
      sweep_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= start_req && !lim_ok;
      if (start_req && lim_ok) begin
        lo_q    <= bus.lo_lim;
        hi_q    <= bus.hi_lim;
        n_q     <= bus.n_sweeps;
        sweep_q <= 4'd0;
      end else if (state == DOWN && !bus.abort && at_bottom) begin
        sweep_q <= sweep_inc;
      end
    end
  end

  // Moore output decode from state.
  always_comb begin
    bus.cnt_en  = 1'b0;
    bus.cnt_dir = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      CLEAR: begin
        bus.cnt_clr = 1'b1;
        bus.busy    = 1'b1;
      end
      UP: begin
        bus.cnt_en = 1'b1;
        bus.busy   = 1'b1;
      end
      DOWN: begin
        bus.cnt_en  = 1'b1;
        bus.cnt_dir = 1'b1;
        bus.busy    = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.err       = err_q;
  assign bus.sweep_cnt = sweep_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural counter on count.
// Each step is checked against hand-computed values with immediate assertions.
module tb_updown_sweep_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  updown_sweep_ctrl_if bus ();

  updown_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled counter: clr -> 0, else en -> +/-1, else hold.
  initial bus.count = 8'h33;
  always @(posedge clk) begin
    if (bus.cnt_clr)     bus.count <= 8'd0;
    else if (bus.cnt_en) bus.count <= bus.cnt_dir ? bus.count - 8'd1 : bus.count + 8'd1;
  end

  // Expected trace for lo=2, hi=5, n=2 starting with the first UP cycle.
  int e_cnt [15] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
  int e_dir [15] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int e_sw  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
  // Tight trace for lo=0, hi=1, n=3.
  int t_cnt [7]  = '{0, 1, 0, 1, 0, 1, 0};
  int t_sw  [7]  = '{0, 0, 1, 1, 2, 2, 3};

  function automatic logic [5:0] outs();
    return {bus.cnt_en, bus.cnt_dir, bus.cnt_clr, bus.busy, bus.done, bus.err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a run and check the CLEAR cycle that must follow.
  task automatic start_run(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] n);
    bus.lo_lim   = lo;
    bus.hi_lim   = hi;
    bus.n_sweeps = n;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("clear_outs", outs(), 6'b001100);
  endtask

  // Follow the first k cycles of the lo=2/hi=5/n=2 trace.
  task automatic follow(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check($sformatf("run_cnt[%0d]", i), bus.count, e_cnt[i]);
      check($sformatf("run_outs[%0d]", i), outs(),
            {(i < 14) ? 1'b1 : 1'b0, e_dir[i] != 0, 1'b0, 1'b1, (i == 14) ? 1'b1 : 1'b0, 1'b0});
      check($sformatf("run_sw[%0d]", i), bus.sweep_cnt, e_sw[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.lo_lim   = 8'd0;
    bus.hi_lim   = 8'd0;
    bus.n_sweeps = 4'd0;
    #2;
    check("reset_outs", outs(), 6'b000000);
    check("reset_sw", bus.sweep_cnt, 4'd0);
    tick();
    check("reset_hold_outs", outs(), 6'b000000);
    rst = 1'b0;
    tick();
    check("idle_outs", outs(), 6'b000000);

    // Normal run.
    start_run(8'd2, 8'd5, 4'd2);
    // Limit changes mid-run must not matter.
    bus.lo_lim = 8'd0;
    bus.hi_lim = 8'd9;
    follow(15);
    tick();
    check("post_done_outs", outs(), 6'b000000);
    check("post_done_sw", bus.sweep_cnt, 4'd2);
    check("post_done_cnt", bus.count, 8'd2);

    // Rejected start: lo == hi.
    bus.lo_lim = 8'd5; bus.hi_lim = 8'd5; bus.n_sweeps = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rej_eq_outs", outs(), 6'b000001);
    check("rej_eq_sw", bus.sweep_cnt, 4'd2);
    tick();
    check("rej_eq_clear", outs(), 6'b000000);

    // Rejected start: n == 0.
    bus.lo_lim = 8'd1; bus.hi_lim = 8'd5; bus.n_sweeps = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rej_n0_outs", outs(), 6'b000001);
    check("rej_n0_sw", bus.sweep_cnt, 4'd2);
    tick();
    check("rej_n0_clear", outs(), 6'b000000);

    // Tight limits: direction alternates every cycle.
    start_run(8'd0, 8'd1, 4'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("tight_cnt[%0d]", i), bus.count, t_cnt[i]);
      check($sformatf("tight_outs[%0d]", i), outs(),
            (i == 6) ? 6'b000110 : {1'b1, (i % 2) == 1, 1'b0, 1'b1, 1'b0, 1'b0});
      check($sformatf("tight_sw[%0d]", i), bus.sweep_cnt, t_sw[i]);
    end
    tick();
    check("tight_idle", outs(), 6'b000000);

    // Abort during the second UP (count 3), counter stepped to 4 on that edge.
    start_run(8'd2, 8'd5, 4'd2);
    follow(10);
    bus.abort = 1'b1;
    tick();
    check("abort_outs", outs(), 6'b000000);
    check("abort_cnt", bus.count, 8'd4);
    bus.abort = 1'b0;
    tick();
    check("abort_frozen_cnt", bus.count, 8'd4);
    check("abort_no_done", outs(), 6'b000000);
    check("abort_sw", bus.sweep_cnt, 4'd1);

    // Subsequent run is normal.
    start_run(8'd2, 8'd5, 4'd2);
    follow(15);
    tick();
    check("rerun_idle", outs(), 6'b000000);

    // Async reset mid-DOWN, between edges.
    start_run(8'd2, 8'd5, 4'd2);
    follow(7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_outs", outs(), 6'b000000);
    check("arst_sw", bus.sweep_cnt, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_release", outs(), 6'b000000);

    // start together with abort in IDLE is ignored.
    bus.lo_lim = 8'd2; bus.hi_lim = 8'd5; bus.n_sweeps = 4'd2;
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    check("start_abort_1", outs(), 6'b000000);
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_2", outs(), 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset: asynchronous, active-high reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  sweep-run request; sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  terminate any run; return to IDLE.
REQ-006 SHALL have port lo_lim  input  8  lower turn-around value; latched on accepted start.
REQ-007 SHALL have port hi_lim  input  8  upper turn-around value; latched on accepted start.
REQ-008 SHALL have port n_sweeps  input  4  number of hi->lo sweeps per run; latched on accepted start.
REQ-009 SHALL have port count  input  8  feedback from the controlled counter.
REQ-010 SHALL have port cnt_en  output  1  counter step enable.
REQ-011 SHALL have port cnt_dir  output  1  counter direction: 0 = up, 1 = down.
REQ-012 SHALL have port cnt_clr  output  1  synchronous clear to the counter.
REQ-013 SHALL have port busy  output  1  high in CLEAR/UP/DOWN/DONE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-016 SHALL have port sweep_cnt  output  4  completed sweeps in the current run.

Function
REQ-017 SHALL assume this counter contract per clk edge: clr -> 0; else en -> count +/- 1 (mod 256) per dir; else hold.
REQ-018 SHALL implement FSM states IDLE, CLEAR, UP, DOWN, DONE.
REQ-019 SHALL decode cnt_en, cnt_dir, cnt_clr, busy and done from state only (Moore): CLEAR = clr 1; UP = en 1, dir 0; DOWN = en 1, dir 1; DONE = done 1; IDLE = all 0.
REQ-020 IDLE: start=1 with abort=0 SHALL latch lo_lim/hi_lim/n_sweeps, zero sweep_cnt, and go to CLEAR, provided lo_lim < hi_lim and n_sweeps != 0.
REQ-021 IDLE: start with lo_lim >= hi_lim or n_sweeps == 0 SHALL pulse err for one cycle and stay in IDLE; no latch takes place.
REQ-022 CLEAR SHALL last exactly one cycle, then go to UP (count becomes 0).
REQ-023 UP: when count == latched hi-1, SHALL go to DOWN (the counter reaches hi on the same edge).
REQ-024 DOWN: when count == latched lo+1, SHALL increment sweep_cnt; go to DONE if the new value equals n_sweeps, else go to UP.
REQ-025 DONE SHALL last one cycle (done=1, cnt_en=0, count held at lo), then go to IDLE; sweep_cnt holds until the next accepted start.
REQ-026 Turn-around values SHALL each appear on count for exactly one cycle; hi-lo = 1 SHALL alternate with no dwell.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next edge without a done pulse; count is left as-is; abort takes priority over all transitions.
REQ-028 start while not IDLE SHALL be ignored; input changes to the limits mid-run SHALL have no effect.
REQ-029 Comparisons SHALL be unsigned 8-bit; hi-1 and lo+1 cannot wrap, given REQ-020.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, with all outputs 0, sweep_cnt 0 and latched registers 0, regardless of clk.
REQ-031 Reset asserted mid-run SHALL abandon the run with no done or err pulse; release SHALL resume in IDLE.

Verification
REQ-032 Normal run: lo=2, hi=5, n=2, start for 1 cycle. Required response:
- CLEAR for 1 cycle, then count 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2.
- sweep_cnt 1 then 2.
- done pulses once with count=2.
- busy falls next cycle.
REQ-033 Rejected start: lo=5, hi=5, n=1 -> err = 1 for 1 cycle, busy stays 0, sweep_cnt unchanged; likewise for n=0.
REQ-034 Tight limits: lo=0, hi=1, n=3 -> count 0,1,0,1,0,1,0, then done; cnt_dir toggles every cycle in UP/DOWN.
REQ-035 Abort: abort during the second UP of REQ-032 -> IDLE next cycle, cnt_en=0, count frozen, no done pulse; a subsequent start runs normally.
REQ-036 Async reset: assert rst mid-DOWN, between clock edges -> outputs 0 immediately; start plus abort together in IDLE -> stays IDLE.
